// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: IF and MEM requester handshakes, the memory-side port, and status.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_req;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_se;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              port_en;
  logic              port_rw;
  logic [1:0]        port_size;
  logic              port_se;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic [DATA_W-1:0] port_rdata;

  logic              grant_mem;
  logic              busy;
  logic              stall_if;
  logic              stall_mem;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
           port_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           port_en, port_rw, port_size, port_se, port_addr, port_wdata,
           grant_mem, busy, stall_if, stall_mem
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
           port_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           port_en, port_rw, port_size, port_se, port_addr, port_wdata,
           grant_mem, busy, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// holding the port for MEM_LAT cycles per grant and returning data with a one-cycle ready.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STREAK_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [STREAK_W-1:0] streak_q,     streak_d;
  logic                port_en_q,    port_en_d;
  logic                port_rw_q,    port_rw_d;
  logic [1:0]          port_size_q,  port_size_d;
  logic                port_se_q,    port_se_d;
  logic [ADDR_W-1:0]   port_addr_q,  port_addr_d;
  logic [DATA_W-1:0]   port_wdata_q, port_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
  logic                if_ready_q,   if_ready_d;
  logic                mem_ready_q,  mem_ready_d;
  logic                grant_mem_q,  grant_mem_d;
  logic                busy_q,       busy_d;
  logic                pick_mem_c;

  // MEM wins ties unless it has already starved a waiting fetch MAX_STREAK times
  assign pick_mem_c = bus.mem_req &
                      ~(bus.if_req & (streak_q == STREAK_W'(MAX_STREAK)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    port_en_d    = port_en_q;
    port_rw_d    = port_rw_q;
    port_size_d  = port_size_q;
    port_se_d    = port_se_q;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    grant_mem_d  = grant_mem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req | bus.mem_req) begin
          state_d     = S_BUSY;
          cnt_d       = CNT_W'(MEM_LAT - 1);
          port_en_d   = 1'b1;
          grant_mem_d = pick_mem_c;
          if (pick_mem_c) begin
            port_rw_d    = bus.mem_rw;
            port_size_d  = bus.mem_size;
            port_se_d    = bus.mem_se;
            port_addr_d  = bus.mem_addr;
            port_wdata_d = bus.mem_wdata;
            if (!bus.if_req)
              streak_d = '0;
            else if (streak_q >= STREAK_W'(MAX_STREAK))
              streak_d = STREAK_W'(MAX_STREAK);
            else
              streak_d = streak_q + STREAK_W'(1);
          end else begin
            port_rw_d    = 1'b0;
            port_size_d  = 2'b10;
            port_se_d    = 1'b0;
            port_addr_d  = bus.if_addr;
            port_wdata_d = '0;
            streak_d     = '0;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          port_en_d = 1'b0;
          // Writes leave the requester's read-data register untouched
          if (!port_rw_q) begin
            if (grant_mem_q) mem_rdata_d = bus.port_rdata;
            else             if_rdata_d  = bus.port_rdata;
          end
          if (grant_mem_q) mem_ready_d = 1'b1;
          else             if_ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      streak_q     <= '0;
      port_en_q    <= 1'b0;
      port_rw_q    <= 1'b0;
      port_size_q  <= '0;
      port_se_q    <= 1'b0;
      port_addr_q  <= '0;
      port_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      grant_mem_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      port_en_q    <= port_en_d;
      port_rw_q    <= port_rw_d;
      port_size_q  <= port_size_d;
      port_se_q    <= port_se_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      grant_mem_q  <= grant_mem_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.port_en    = port_en_q;
  assign bus.port_rw    = port_rw_q;
  assign bus.port_size  = port_size_q;
  assign bus.port_se    = port_se_q;
  assign bus.port_addr  = port_addr_q;
  assign bus.port_wdata = port_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.grant_mem  = grant_mem_q;
  assign bus.busy       = busy_q;

  // Stalls gate the pipeline latches in the same cycle the request is pending
  assign bus.stall_if  = bus.if_req  & ~if_ready_q;
  assign bus.stall_mem = bus.mem_req & ~mem_ready_q;

endmodule
